regfile_wb_ctrl: RTL and testbench

Write-side controller for the 32x32 register file. Accepts writeback requests from two producers (single-cycle ALU, multi-cycle load/mult/div), queues them in order in a small FIFO, and drains one per cycle onto the register file write port (wren/wr/wd). Also publishes a per-register pending mask so decode can stall. Sits between execute/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_fifo.sv | 56 +++++
 rtl/regfile_wb_ctrl.sv | 137 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path.
// Holds register address/data widths and the queued writeback request record.
// Imported by the writeback FIFO and the writeback controller.
package regfile_pkg;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t dst;
    word_t     data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Purpose: in-order writeback request queue with two ordered push ports and one pop.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: none internally; the caller must never push past DEPTH or pop when empty.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  wb_req_t                  data0,
  input  logic                     push1,
  input  wb_req_t                  data1,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output wb_req_t                  ent [DEPTH],
  output logic [DEPTH-1:0]         vld
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t         mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr1;

  // push1 lands behind push0 when both fire, so port 0 is always the older entry
  assign wptr1 = push0 ? wptr + PW'(1) : wptr;
  assign head  = mem[rptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push0) mem[wptr]  <= data0;
      if (push1) mem[wptr1] <= data1;
      wptr  <= wptr + PW'(push0) + PW'(push1);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // age-ordered view: index 0 is the oldest entry, higher indices are younger
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent[k] = mem[rptr + PW'(k)];
      vld[k] = (CW'(k) < count);
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Purpose: merges ALU and load/mult/div writebacks into one in-order register file write port.
// Latency: accept at edge k, write presented on wren/wr/wd after edge k+1 when the queue is empty.
// Backpressure: readies from current occupancy only; B yields to A when one slot is left. Bypass via REGFILE_WB_BYPASS_EN.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_reg,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_reg,
  input  logic [31:0]              b_data,
  output logic                     wren,
  output logic [4:0]               wr,
  output logic [31:0]              wd,
  output logic [NUM_REGS-1:0]      busy,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [4:0]               rr1,
  input  logic [4:0]               rr2,
  output logic                     fwd1_hit,
  output logic [31:0]              fwd1_data,
  output logic                     fwd2_hit,
  output logic [31:0]              fwd2_data
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    fifo_count;
  logic             room1;
  logic             room2;
  logic             a_take;
  logic             b_take;
  logic             pop;
  wb_req_t          head;
  wb_req_t          ent [DEPTH];
  logic [DEPTH-1:0] vld;

  assign count = fifo_count;
  assign room1 = fifo_count < CW'(DEPTH);
  assign room2 = fifo_count <= CW'(DEPTH - 2);

  assign a_ready = !rst && room1;
  assign b_ready = !rst && (room2 || (room1 && !a_valid));

  // writes to r0 complete the handshake but never occupy a slot
  assign a_take = a_valid && a_ready && (a_reg != '0);
  assign b_take = b_valid && b_ready && (b_reg != '0);
  assign pop    = (fifo_count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (a_take),
    .data0 ('{dst: a_reg, data: a_data}),
    .push1 (b_take),
    .data1 ('{dst: b_reg, data: b_data}),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .ent   (ent),
    .vld   (vld)
  );

  // output stage: drain one entry per cycle; address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren <= 1'b0;
      wr   <= '0;
      wd   <= '0;
    end else begin
      wren <= pop;
      if (pop) begin
        wr <= head.dst;
        wd <= head.data;
      end
    end
  end

  // pending-write mask over queued entries plus the output stage
  always_comb begin
    busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k]) busy[ent[k].dst] = 1'b1;
    end
    if (wren) busy[wr] = 1'b1;
    busy[0] = 1'b0;
  end

`ifdef REGFILE_WB_BYPASS_EN
  // youngest-match lookup: output stage is oldest, later queue entries override
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (wren && wr == rr1) begin
      fwd1_hit  = 1'b1;
      fwd1_data = wd;
    end
    if (wren && wr == rr2) begin
      fwd2_hit  = 1'b1;
      fwd2_data = wd;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k] && ent[k].dst == rr1) begin
        fwd1_hit  = 1'b1;
        fwd1_data = ent[k].data;
      end
      if (vld[k] && ent[k].dst == rr2) begin
        fwd2_hit  = 1'b1;
        fwd2_data = ent[k].data;
      end
    end
    if (rr1 == '0) begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
    end
    if (rr2 == '0) begin
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
    end
  end
`else
  // lookup disabled: read addresses are intentionally left unused
  logic unused_rr;
  assign unused_rr = ^{rr1, rr2};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed steps followed by randomized traffic.
// Expected values come from a queue-based model of the writeback rules.
// Checks every output once per cycle, away from the clock edge.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg, b_reg, rr1, rr2;
  logic [31:0] a_data, b_data;
  logic        wren;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [31:0] busy;
  logic [2:0]  count;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .wren(wren), .wr(wr), .wd(wd), .busy(busy), .count(count),
    .rr1(rr1), .rr2(rr2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: ordered list of pending writes plus the presented write
  wb_req_t     q[$];
  logic        m_wren = 1'b0;
  logic [4:0]  m_wr   = '0;
  logic [31:0] m_wd   = '0;
  logic [31:0] rf_dut [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_wren = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
  endtask

  function automatic logic [32:0] lookup(input logic [4:0] rr);
    logic        hit = 1'b0;
    logic [31:0] d   = '0;
`ifdef REGFILE_WB_BYPASS_EN
    if (rr != 0) begin
      if (m_wren && m_wr == rr) begin hit = 1'b1; d = m_wd; end
      foreach (q[i]) if (q[i].dst == rr) begin hit = 1'b1; d = q[i].data; end
    end
`endif
    return {hit, d};
  endfunction

  task automatic check_all();
    int          free;
    logic [31:0] eb;
    logic [32:0] f1, f2;
    if (rst) model_clear();
    free = DEPTH - q.size();
    eb = '0;
    foreach (q[i]) eb[q[i].dst] = 1'b1;
    if (m_wren) eb[m_wr] = 1'b1;
    eb[0] = 1'b0;
    f1 = lookup(rr1);
    f2 = lookup(rr2);
    chk("a_ready", a_ready, !rst && free >= 1);
    chk("b_ready", b_ready, !rst && (free >= 2 || (free >= 1 && !a_valid)));
    chk("wren", wren, m_wren);
    chk("wr", wr, m_wr);
    chk("wd", wd, m_wd);
    chk("count", count, q.size());
    chk("busy", busy, eb);
    chk("fwd1_hit", fwd1_hit, f1[32]);
    chk("fwd1_data", fwd1_data, f1[31:0]);
    chk("fwd2_hit", fwd2_hit, f2[32]);
    chk("fwd2_data", fwd2_data, f2[31:0]);
  endtask

  task automatic model_edge();
    int      free;
    logic    acc_a, acc_b;
    wb_req_t e;
    if (rst) begin
      model_clear();
      return;
    end
    free  = DEPTH - q.size();
    acc_a = a_valid && free >= 1;
    acc_b = b_valid && (free >= 2 || (free >= 1 && !a_valid));
    if (q.size() > 0) begin
      e = q.pop_front();
      m_wren = 1'b1;
      m_wr   = e.dst;
      m_wd   = e.data;
    end else begin
      m_wren = 1'b0;
    end
    if (acc_a && a_reg != 0) q.push_back('{dst: a_reg, data: a_data});
    if (acc_b && b_reg != 0) q.push_back('{dst: b_reg, data: b_data});
  endtask

  // inputs are set at the falling edge; checks land 2 time units later
  task automatic tick();
    #2;
    check_all();
    if (wren) rf_dut[wr] = wd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    foreach (rf_dut[i]) rf_dut[i] = '0;
    rst = 1'b1; rr1 = '0; rr2 = '0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single ALU write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("busy5_after_accept", busy[5], 1'b1);
    chk("wren_after_accept", wren, 1'b0);
    tick();
    chk("wren_presented", wren, 1'b1);
    chk("wr_presented", wr, 5'd5);
    chk("wd_presented", wd, 32'hDEADBEEF);
    chk("busy5_presented", busy[5], 1'b1);
    tick();
    chk("busy5_cleared", busy[5], 1'b0);
    idle(2);

    // same-cycle A and B to one register: A is older, B wins
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
    tick();
    idle(3);
    chk("rf3_final", rf_dut[3], 32'h2);

    // saturate with both producers held valid
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    idle(5);

    // write to r0 is swallowed
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("r0_count", count, 3'd0);
    chk("r0_busy", busy, 32'h0);
    tick();
    chk("r0_no_wren", wren, 1'b0);
    idle(1);

    // forwarding picks the youngest pending write
    rr1 = 5'd7; rr2 = 5'd0;
    drive(1'b1, 5'd7, 32'h10, 1'b1, 5'd7, 32'h20);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
`ifdef REGFILE_WB_BYPASS_EN
    chk("fwd1_hit_r7", fwd1_hit, 1'b1);
    chk("fwd1_data_r7", fwd1_data, 32'h20);
`else
    chk("fwd1_hit_off", fwd1_hit, 1'b0);
    chk("fwd1_data_off", fwd1_data, 32'h0);
`endif
    chk("fwd2_hit_r0", fwd2_hit, 1'b0);
    idle(4);
    rr1 = '0;

    // reset with writes in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("pre_rst_count", count, 3'd3);
    rst = 1'b1;
    #1;
    chk("rst_count_now", count, 3'd0);
    chk("rst_busy_now", busy, 32'h0);
    chk("rst_wren_now", wren, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_a_ready", a_ready, 1'b1);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      rr1 = 5'($urandom_range(0, 7));
      rr2 = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
